cell_array_sequencer: RTL
=========================

Name: cell_array_sequencer

Overview:
- Top-level sequencer for the physics cell array.
- Drives the shared CONV_FLAG and Load lines of every cell FSM and gates the array shift enable.
- Runs a programmable number of timesteps. Each timestep is a shift phase (N_CELLS cycles) followed by a convolution phase (CONV_CYCLES cycles); the array is loaded once at the start of a run.
- Sits between the host/control interface (Start/NumSteps/Hold) and the cell array.

Parameters:
- N_CELLS, 8: shift-phase length in cycles (cells per chain); ≥1.
- CONV_CYCLES, 4: convolution-phase length in cycles; ≥1.
- STEP_W, 8: width of the timestep count.
- CNT_W, 8: width of the internal phase counter; must hold max(N_CELLS, CONV_CYCLES).

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle run request; ignored while Busy.
- NumSteps  in  STEP_W  number of timesteps; latched on accepted Start.
- Hold  in  1  stall; freezes state and counters while high.
- CONV_FLAG  out  1  high during convolution phase; drives cell CONV_FLAG.
- Load  out  1  one-cycle array load strobe.
- ShiftEn  out  1  array shift enable.
- ShiftCount  out  CNT_W  current phase counter.
- StepCount  out  STEP_W  completed timesteps in the current run.
- Busy  out  1  high in any state except IDLE.
- Done  out  1  one-cycle pulse when a run completes.

Behaviour:
- States: IDLE, LOAD, SHIFT, CONV, WRAP. State, counters and the latched step count are registers.
- All outputs decode from registers only, except ShiftEn = (state==SHIFT) & ~Hold.
- Reset (synchronous, wins over every other input):
  - Next state is IDLE.
  - ShiftCount = 0, StepCount = 0, latched steps = 0.
  - CONV_FLAG = Load = ShiftEn = Busy = Done = 0.
- IDLE:
  - Start=1 with NumSteps≠0 → LOAD; latch NumSteps; StepCount cleared to 0.
  - Start=1 with NumSteps=0 → stay IDLE; Done pulses the next cycle; Load never asserts.
- LOAD: Load=1 for exactly one cycle, then SHIFT with ShiftCount=0. Hold is ignored in LOAD.
- SHIFT:
  - ShiftEn asserts while Hold=0, and ShiftCount increments.
  - After N_CELLS un-held cycles (ShiftCount==N_CELLS-1 and Hold=0) → CONV with ShiftCount=0.
- CONV:
  - CONV_FLAG=1 for the whole phase, including held cycles.
  - After CONV_CYCLES un-held cycles → WRAP.
- WRAP (1 cycle, Hold ignored):
  - StepCount increments.
  - If the new StepCount equals the latched steps → IDLE with Done=1 in the first IDLE cycle.
  - Otherwise → SHIFT with ShiftCount=0. There is no reload between timesteps.
- Hold:
  - While high in SHIFT or CONV, state and ShiftCount are frozen.
  - In SHIFT, ShiftEn drops combinationally during held cycles.
- Timing:
  - Start accepted at edge t → LOAD in cycle t+1.
  - With no Hold, a run is Busy for 1 + S·(N_CELLS+CONV_CYCLES+1) cycles; Done follows immediately.
- Start while Busy: ignored; latched steps are unchanged.
- StepCount holds its final value in IDLE until the next accepted Start or Reset.
- NumSteps = 2^STEP_W−1 runs the full count; StepCount never wraps within a run.
- Mutual exclusion: CONV_FLAG, Load and ShiftEn are never high in the same cycle.
- Reset mid-run: the run aborts, no Done, IDLE next cycle.

Test Plan:
- Reset behaviour: Reset=1 for 2 cycles, then release → all outputs 0 and state IDLE. Start on the cycle after release is accepted.
- Normal run (N_CELLS=8, CONV_CYCLES=4), Start with NumSteps=2 →
  - Load high exactly 1 cycle.
  - ShiftEn high 8 cycles, then CONV_FLAG high 4 cycles; this shift/convolution pair occurs twice.
  - Busy high 27 cycles, then Done pulses once; StepCount reads 2.
- Hold: hold asserted 3 cycles mid-SHIFT and 2 cycles mid-CONV, NumSteps=1 →
  - ShiftEn low and ShiftCount frozen during the held shift cycles.
  - CONV_FLAG stays high during the held convolution cycles.
  - Total Busy = 14+5 = 19 cycles.
- Zero steps: Start with NumSteps=0 → Busy never asserts, Load never asserts, Done pulses on the next cycle.
- Start while busy: Start pulsed during CONV with NumSteps=5, original run NumSteps=1 → ignored; run ends after 1 step; exactly one Done.
- Reset mid-run: Reset asserted during SHIFT of step 1 of 3, simultaneous with Start → IDLE next cycle, no Done, all outputs 0. A subsequent Start runs a full fresh sequence.

Source files
------------

// File: rtl/cell_array_sequencer.sv
// Sequencer for the physics cell array: loads the array once per run, then runs
// a programmable number of timesteps of (shift phase, convolution phase).
module cell_array_sequencer #(
    parameter int N_CELLS     = 8,
    parameter int CONV_CYCLES = 4,
    parameter int STEP_W      = 8,
    parameter int CNT_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [STEP_W-1:0] NumSteps,
    input  logic              Hold,
    output logic              CONV_FLAG,
    output logic              Load,
    output logic              ShiftEn,
    output logic [CNT_W-1:0]  ShiftCount,
    output logic [STEP_W-1:0] StepCount,
    output logic              Busy,
    output logic              Done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CONV  = 3'd3,
        WRAP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(N_CELLS - 1);
    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] steps;
    logic [STEP_W-1:0] step_inc;
    logic              shift_end;
    logic              conv_end;

    assign step_inc  = StepCount + STEP_W'(1);
    assign shift_end = (ShiftCount == SHIFT_LAST) && !Hold;
    assign conv_end  = (ShiftCount == CONV_LAST) && !Hold;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples values from before the edge, independent of block order.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start && (NumSteps != '0)) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (shift_end) state_next = CONV;
            CONV:    if (conv_end) state_next = WRAP;
            WRAP:    state_next = (step_inc == steps) ? IDLE : SHIFT;
            default: state_next = IDLE;
        endcase
    end

    // Counters, latched step count and the registered Done pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ShiftCount <= '0;
            StepCount  <= '0;
            steps      <= '0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        steps     <= NumSteps;
                        StepCount <= '0;
                        // A zero-length run completes immediately without loading.
                        if (NumSteps == '0) Done <= 1'b1;
                    end
                end
                LOAD: ShiftCount <= '0;
                SHIFT: begin
                    if (!Hold) ShiftCount <= shift_end ? '0 : ShiftCount + CNT_W'(1);
                end
                CONV: begin
                    if (!Hold) ShiftCount <= conv_end ? '0 : ShiftCount + CNT_W'(1);
                end
                WRAP: begin
                    StepCount  <= step_inc;
                    ShiftCount <= '0;
                    if (step_inc == steps) Done <= 1'b1;
                end
                default: ShiftCount <= '0;
            endcase
        end
    end

    // Outputs decode from the state register; only ShiftEn also sees Hold.
    always_comb begin
        CONV_FLAG = (state == CONV);
        Load      = (state == LOAD);
        ShiftEn   = (state == SHIFT) && !Hold;
        Busy      = (state != IDLE);
    end

endmodule
